// File: rtl/acc_drain.sv
// acc_drain: snapshot N accumulator lanes and stream them out requantized (shift + saturate).
module acc_drain #(
  parameter int N       = 4,
  parameter int D_W_ACC = 32,
  parameter int D_W_OUT = 8,
  parameter int SHIFT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap_valid,
  output logic                 cap_ready,
  input  logic [N*D_W_ACC-1:0] cap_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [D_W_OUT-1:0]   m_data,
  output logic                 m_last,
  output logic                 m_sat
);
  localparam int IW = $clog2(N);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t                      state;
  logic [IW-1:0]               idx;
  logic [D_W_ACC-1:0]          buffer [N];
  logic signed [D_W_ACC-1:0]   s;
  logic [D_W_ACC-D_W_OUT:0]    top;
  logic                        fits;
  logic                        at_end;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      for (int i = 0; i < N; i++) buffer[i] <= '0;
    end else if (state == IDLE) begin
      if (cap_valid) begin
        for (int i = 0; i < N; i++) buffer[i] <= cap_data[i*D_W_ACC +: D_W_ACC];
        idx   <= '0;
        state <= DRAIN;
      end
    end else if (m_ready) begin
      idx   <= at_end ? '0 : idx + IW'(1);
      state <= at_end ? IDLE : DRAIN;
    end
  end
  // In range iff every bit from the output sign bit upward agrees.
  always_comb begin
    at_end    = idx == IW'(N - 1);
    cap_ready = state == IDLE;
    m_valid   = state == DRAIN;
    s         = $signed(buffer[idx]) >>> SHIFT;
    top       = s[D_W_ACC-1:D_W_OUT-1];
    fits      = (&top) | ~(|top);
    m_data    = !m_valid ? '0 : fits ? s[D_W_OUT-1:0] : {s[D_W_ACC-1], {(D_W_OUT-1){~s[D_W_ACC-1]}}};
    m_last    = m_valid && at_end;
    m_sat     = m_valid && !fits;
  end
endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain: randomized scoreboard bench for acc_drain against a floor-divide/clip model.
module tb_acc_drain;
  localparam int N = 4, W = 32, OW = 8, SH = 4;
  logic clk = 0, rst = 1, cap_valid = 0, m_ready = 1;
  logic cap_ready, m_valid, m_last, m_sat;
  logic [N*W-1:0] cap_data = '0;
  logic [OW-1:0] m_data;
  typedef struct packed {logic [OW-1:0] d; logic l; logic s;} beat_t;
  beat_t q[$];
  int vectors = 0, errors = 0, beats = 0, cyc = 0, last_cyc = -10;
  bit rand_ready = 0, force_lo = 0;

  acc_drain #(.N(N), .D_W_ACC(W), .D_W_OUT(OW), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_data(cap_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_sat(m_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1 m_ready = force_lo ? 1'b0 : rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: floor division by 2^SH, then clip to the signed output range.
  function automatic beat_t model(input int a, input bit last);
    longint v = a, dv = longint'(1) << SH, s, mx, mn;
    beat_t b;
    mx = (longint'(1) << (OW - 1)) - 1;
    mn = -(longint'(1) << (OW - 1));
    s = (v >= 0) ? v / dv : -((-v + dv - 1) / dv);
    b.l = last;
    if (s > mx) begin b.d = OW'(mx); b.s = 1; end
    else if (s < mn) begin b.d = OW'(mn); b.s = 1; end
    else begin b.d = OW'(s); b.s = 0; end
    return b;
  endfunction

  always @(negedge clk) if (!rst) begin
    check("cap_ready_vs_valid", cap_ready, !m_valid);
    if (!m_valid) check("idle_outputs", {m_data, m_last, m_sat}, 0);
    else if (q.size() == 0) begin
      vectors++; errors++;
      $display("FAIL unexpected_beat: got data %0h with empty scoreboard", m_data);
    end else begin
      check("m_data", m_data, q[0].d);
      check("m_last", m_last, q[0].l);
      check("m_sat", m_sat, q[0].s);
      if (m_ready) begin
        void'(q.pop_front());
        beats++;
        if (m_last) last_cyc = cyc;
      end
    end
  end

  task automatic capture(input int a, input int b, input int c, input int d, input bit blk);
    int ln[N];
    int waited = 0;
    bit got = 0;
    ln = '{a, b, c, d};
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) cap_data[i*W +: W] = ln[i];
    cap_valid = 1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      #1;
      if (cap_ready) got = 1; else waited++;
    end
    if (!got) begin
      vectors++; errors++;
      $display("FAIL capture_timeout: cap_ready stayed 0 expected 1");
      cap_valid = 0;
      return;
    end
    if (blk) begin
      check("blocked_during_drain", waited > 0, 1);
      check("capture_first_idle", cyc - last_cyc, 1);
      check("old_snapshot_done", q.size(), 0);
    end
    for (int i = 0; i < N; i++) q.push_back(model(ln[i], i == N - 1));
    @(posedge clk);
    #1;
    cap_valid = 0;
    cap_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    #1 check("first_beat_latency", m_valid, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    check("drain_complete", q.size(), 0);
  endtask

  task automatic wait_beats(input int n);
    for (int k = 0; k < 100 && beats < n; k++) begin
      @(negedge clk);
      #1;
    end
    check("beat_progress", beats >= n, 1);
  endtask

  function automatic int rv();
    case ($urandom_range(0, 2))
      0: return int'($urandom);
      1: return int'($urandom_range(0, 8000)) - 4000;
      default: return int'($urandom_range(0, 400)) - 200;
    endcase
  endfunction

  initial begin
    int b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_cap_ready", cap_ready, 1);
    check("rst_outputs", {m_data, m_last, m_sat}, 0);
    @(posedge clk);
    #1 rst = 0;
    capture(16, 'h7F0, -32, 0, 0);
    drain();
    capture('h1000, -'h810, 'h7FF, -'h800, 0);
    drain();
    b0 = beats;
    capture(100, 200, -300, 400, 0);
    wait_beats(b0 + 1);
    force_lo = 1;
    repeat (4) @(posedge clk);
    force_lo = 0;
    drain();
    check("backpressure_beats", beats - b0, 4);
    capture(1, 2, 3, 4, 0);
    capture(-'h5000, 'h333, 'h9, -'h70, 1);
    drain();
    b0 = beats;
    capture(500, 600, 700, 800, 0);
    wait_beats(b0 + 2);
    @(posedge clk);
    #1 rst = 1;
    q.delete();
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("abort_m_valid", m_valid, 0);
    check("abort_cap_ready", cap_ready, 1);
    capture(-'h18, -1, 'h1F, 'h0F, 0);
    drain();
    rand_ready = 1;
    repeat (30) begin
      capture(rv(), rv(), rv(), rv(), 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rand_ready = 0;
    drain();
    repeat (3) @(posedge clk);
    check("final_queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end
endmodule
